// File: rtl/sdram_fifo_pkg.sv
// Shared types and width helpers for the SDRAM-path FIFOs.
package sdram_fifo_pkg;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port FIFO storage: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DataWidth = 16,
    parameter int Depth     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(Depth)-1:0]   i_wr_addr,
    input  logic [DataWidth-1:0]       i_wr_data,
    input  logic [$clog2(Depth)-1:0]   i_rd_addr,
    output logic [DataWidth-1:0]       o_rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through FIFO controller around fifo_mem.
// Define SYNC_FIFO_CTRL_WATERMARK_EN to enable registered almost-full/almost-empty flags.
module sync_fifo_ctrl
    import sdram_fifo_pkg::*;
#(
    parameter int DataWidth      = 16,
    parameter int Depth          = 8,
    parameter int AlmostFullThr  = 6,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [DataWidth-1:0]          i_wr_data,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [DataWidth-1:0]          o_rd_data,
    output logic [fifo_addr_w(Depth):0]   o_count,
    output logic                          o_almost_full,
    output logic                          o_almost_empty
);

    localparam int AddrWidth = fifo_addr_w(Depth);
    typedef logic [AddrWidth:0] ptr_t;
    typedef logic [AddrWidth:0] count_t;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_ctrl: Depth must be a power of two >= 2");
    end
    if (AlmostFullThr < 0 || AlmostFullThr > Depth ||
        AlmostEmptyThr < 0 || AlmostEmptyThr > Depth) begin : g_bad_thr
        $error("sync_fifo_ctrl: watermark thresholds must lie in 0..Depth");
    end

    ptr_t         wr_ptr, rd_ptr;
    count_t       count_q, next_count;
    fifo_status_t status;
    logic         wr_fire, rd_fire;
    logic         af_flag, ae_flag;

    always_comb begin
        status              = '0;
        status.empty        = (wr_ptr == rd_ptr);
        status.full         = (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]) &&
                              (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]);
        status.almost_full  = af_flag;
        status.almost_empty = ae_flag;
    end

    assign o_wr_ready = !status.full && !i_rst;
    assign o_rd_valid = !status.empty;

    // Flush wins over both handshakes; reset already drops ready on the write side.
    assign wr_fire = i_wr_valid && o_wr_ready && !i_flush;
    assign rd_fire = o_rd_valid && i_rd_ready && !i_flush && !i_rst;

    always_comb begin
        next_count = count_q;
        if (i_rst || i_flush) begin
            next_count = '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   next_count = count_q + count_t'(1);
                2'b01:   next_count = count_q - count_t'(1);
                default: next_count = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_fire) rd_ptr <= rd_ptr + ptr_t'(1);
            count_q <= next_count;
        end
    end

`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
    localparam count_t AfThr = count_t'(AlmostFullThr);
    localparam count_t AeThr = count_t'(AlmostEmptyThr);

    // Flags look at next_count so they move in the same cycle as o_count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            af_flag <= 1'b0;
            ae_flag <= 1'b1;
        end else begin
            af_flag <= (next_count >= AfThr);
            ae_flag <= (next_count <= AeThr);
        end
    end
`else
    assign af_flag = 1'b0;
    assign ae_flag = 1'b0;
`endif

    assign o_count        = count_q;
    assign o_almost_full  = status.almost_full;
    assign o_almost_empty = status.almost_empty;

    fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (wr_fire),
        .i_wr_addr (wr_ptr[AddrWidth-1:0]),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_ptr[AddrWidth-1:0]),
        .o_rd_data (o_rd_data)
    );

    a_no_wr_full:  assert property (@(posedge i_clk) disable iff (i_rst) !(wr_fire && status.full));
    a_no_rd_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(rd_fire && status.empty));
    a_count_max:   assert property (@(posedge i_clk) int'(count_q) <= Depth);
    a_count_ptrs:  assert property (@(posedge i_clk) count_q == ptr_t'(wr_ptr - rd_ptr));

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the team's dual-port RAM `fifo_mem`, which has an async read port and a sync write port. It owns the read/write pointers, the full/empty/count state and valid/ready handshakes on both sides. The output is first-word-fall-through. It is used as the command and read-data buffer between the host interface and the SDRAM controller core.

Parameters:
DataWidth, 16, width of one FIFO word
Depth, 8, number of entries; power of two, >= 2
AlmostFullThr, 6, `o_almost_full` asserted when count >= this value (watermark feature only)
AlmostEmptyThr, 2, `o_almost_empty` asserted when count <= this value (watermark feature only)

Ports:
i_clk  input  1  clock; all state updates on its rising edge
i_rst  input  1  synchronous, active-high reset
i_flush  input  1  synchronous clear of FIFO contents
i_wr_valid  input  1  producer has a word
o_wr_ready  output  1  FIFO can accept a word
i_wr_data  input  DataWidth  write word
o_rd_valid  output  1  head word available
i_rd_ready  input  1  consumer takes the head word
o_rd_data  output  DataWidth  head word, async from RAM at the read pointer
o_count  output  $clog2(Depth)+1  current occupancy, 0..Depth
o_almost_full  output  1  watermark flag (feature only)
o_almost_empty  output  1  watermark flag (feature only)

Behaviour:
- Clock and reset: one clock, `i_clk`; reset `i_rst` is synchronous and active-high.
- Pointers: `wr_ptr` and `rd_ptr` are AddrWidth+1 bits, with AddrWidth = $clog2(Depth). RAM addresses use the low AddrWidth bits; the MSB is the wrap bit.
- Empty: `wr_ptr == rd_ptr`. Full: low bits equal and MSBs differ.
- Count: `o_count = wr_ptr - rd_ptr`, modulo 2^(AddrWidth+1), held in a registered counter that equals this expression.
- Handshake outputs: `o_wr_ready = !full && !i_rst`; `o_rd_valid = !empty`. Both are combinational from registered state.
- Transfers: a write occurs when `i_wr_valid && o_wr_ready`, driving the RAM write enable, address `wr_ptr[AddrWidth-1:0]` and `i_wr_data`. A read occurs when `o_rd_valid && i_rd_ready`.
- Latency: a word written in cycle N is visible on `o_rd_data` with `o_rd_valid = 1` in cycle N+1 (single-cycle write-to-read). `o_rd_data` changes combinationally when `rd_ptr` advances.
- Simultaneous read and write on a non-empty, non-full FIFO: both pointers advance; count unchanged.
- Full: writes are refused (ready low); a read may proceed. The write refused this cycle is accepted next cycle once ready rises.
- Empty: reads are refused. A same-cycle write is not bypassed to the read side; the word appears next cycle.
- Wrap-around: pointers increment modulo 2^(AddrWidth+1); full/empty stay correct across any number of wraps.
- Reset: `wr_ptr = rd_ptr = 0`, count 0, `o_rd_valid = 0`, `o_wr_ready = 0` during reset and 1 the cycle after. `o_almost_empty = 1`, `o_almost_full = 0`. RAM contents are not cleared; `o_rd_data` is don't-care while empty.
- Reset mid-operation: all in-flight words are discarded; a same-cycle write is not performed (write enable gated off).
- Flush: `i_flush` behaves like reset for pointers, count and flags, but `o_wr_ready` stays high (if not full pre-flush, it is 1 after). Flush overrides same-cycle read and write, and neither handshake counts as a transfer.
- Assertions: no write when full, no read when empty, count <= Depth, Depth is a power of two (elaboration check).

Optional Feature:
Macro: `SYNC_FIFO_CTRL_WATERMARK_EN`.
- Defined: registered `o_almost_full = (next_count >= AlmostFullThr)` and `o_almost_empty = (next_count <= AlmostEmptyThr)`, updated in the same cycle as `o_count`.
- Undefined: both outputs are tied to 0, the threshold parameters are unused, and no comparator logic is synthesized.

Decomposition:
- Shared package `sdram_fifo_pkg`: the `ptr_t`/`count_t` width helper function `fifo_addr_w(Depth)` and a `fifo_status_t` struct {full, empty, almost_full, almost_empty}.
- One sub-module: the existing `fifo_mem` instance (`DataWidth`, `Depth` passed through).
- Pointer, flag and count logic stays in this module.

Test Plan:
- Reset then write 0x0001..0x0008 with `i_rd_ready = 0` -> after the 8th write `o_wr_ready = 0`, `o_count = 8`; a 9th write is refused and `o_count` stays 8.
- Drain the full FIFO with `i_rd_ready = 1` -> `o_rd_data` reads 0x0001..0x0008 in order, one per cycle; then `o_rd_valid = 0`, `o_count = 0`.
- Continuous simultaneous read+write for 20 cycles at count 3 -> count stays 3, data in order, pointers wrap at least twice, no flag glitch.
- Write 0xABCD to an empty FIFO in cycle N with `i_rd_ready = 1` -> `o_rd_valid` rises in N+1 with `o_rd_data = 0xABCD`; no read in cycle N.
- Flush at count 5 with a write asserted in the same cycle -> next cycle `o_count = 0`, `o_rd_valid = 0`, `o_wr_ready = 1`, the written word is lost.
- Watermark build: fill to 6 -> `o_almost_full` rises in the cycle `o_count` becomes 6; drain to 2 -> `o_almost_empty` rises. Non-watermark build: both outputs are constant 0.
